// File: rtl/pb_press_ctrl_if.sv
// Push-button front-end bus.
// Groups the raw button pin and the three debounced results into one bundle.
//   PB      : raw push button, asynchronous, active-low (0 = pressed)
//   pressed : one-clock pulse when a press is accepted
//   held    : one-clock pulse when a press has lasted the long-hold time
//   down    : debounced level, 1 = button pressed
// master : the side that owns the pin and consumes the results (board / bench)
// slave  : the debouncer itself
interface pb_press_ctrl_if;
  logic PB;
  logic pressed;
  logic held;
  logic down;

  modport master (output PB, input pressed, input held, input down);
  modport slave  (input PB, output pressed, output held, output down);
endinterface

// File: rtl/pb_press_ctrl.sv
// Press-side front end for the operator push button.
// Synchronises the raw active-low PB pin through two flops, debounces both
// edges with a cycle counter, and produces:
//   pressed : one-clock pulse once a press has been stable for DEB_CYCLES
//   held    : one-clock pulse after HOLD_CYCLES spent in the pressed state
//             (at most once per press)
//   down    : debounced level, 1 while the button is considered pressed
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   pb_if  : slave side of pb_press_ctrl_if (PB in; pressed/held/down out)
// All outputs come straight from flops; PB has no combinational path out.
module pb_press_ctrl #(
  parameter int unsigned DEB_CYCLES  = 500_000,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic            clk,
  input  logic            rst_n,
  pb_press_ctrl_if.slave  pb_if
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_DEB = 3'd1,
    DOWN      = 3'd2,
    HELD      = 3'd3,
    REL_DEB   = 3'd4
  } state_t;

  logic             q1_r;
  logic             q2_r;
  logic             pb_s;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;        // press debounce, then hold count
  logic [CNT_W-1:0] rel_cnt_r;    // release debounce only
  logic             held_done_r;  // held already fired for this press
  logic             pressed_r;
  logic             held_r;
  logic             down_r;

  // Two-flop synchroniser; resets to 1 so reset reads as "not pressed".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_r <= 1'b1;
      q2_r <= 1'b1;
    end else begin
      q1_r <= pb_if.PB;
      q2_r <= q1_r;
    end
  end

  assign pb_s = q2_r;

  // Debounce / hold FSM with registered pulse and level outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      rel_cnt_r   <= CNT_ZERO;
      held_done_r <= 1'b0;
      pressed_r   <= 1'b0;
      held_r      <= 1'b0;
      down_r      <= 1'b0;
    end else begin
      pressed_r <= 1'b0;
      held_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!pb_s) begin
            state_r     <= PRESS_DEB;
            cnt_r       <= CNT_ZERO;
            held_done_r <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        PRESS_DEB: begin
          if (pb_s) begin
            state_r <= IDLE;
          end else if (cnt_r == DEB_LAST) begin
            state_r   <= DOWN;
            cnt_r     <= CNT_ZERO;
            pressed_r <= 1'b1;
            down_r    <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DOWN: begin
          // A release sample takes priority over the hold terminal count.
          if (pb_s) begin
            state_r   <= REL_DEB;
            rel_cnt_r <= CNT_ZERO;
          end else if (cnt_r == HOLD_LAST) begin
            state_r     <= HELD;
            held_r      <= 1'b1;
            held_done_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        HELD: begin
          if (pb_s) begin
            state_r   <= REL_DEB;
            rel_cnt_r <= CNT_ZERO;
          end else begin
            state_r <= HELD;
          end
        end
        REL_DEB: begin
          // Bounce back to the pressed state keeps the frozen hold count.
          if (!pb_s) begin
            state_r <= held_done_r ? HELD : DOWN;
          end else if (rel_cnt_r == DEB_LAST) begin
            state_r <= IDLE;
            down_r  <= 1'b0;
          end else begin
            rel_cnt_r <= rel_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= CNT_ZERO;
          rel_cnt_r   <= CNT_ZERO;
          held_done_r <= 1'b0;
          down_r      <= 1'b0;
        end
      endcase
    end
  end

  assign pb_if.pressed = pressed_r;
  assign pb_if.held    = held_r;
  assign pb_if.down    = down_r;

endmodule

// File: tb/tb_pb_press_ctrl.sv
// Directed bench for pb_press_ctrl with DEB_CYCLES=4, HOLD_CYCLES=16.
// Stimulus convention: PB for "edge k" is driven on the falling edge before
// rising edge k; outputs are sampled 1 time unit after rising edge k.
// With PB first low at edge 0, pressed is expected after edge 6, held after
// edge 22 (uninterrupted hold), and down falls 6 edges after the first edge
// that samples PB high.
module tb_pb_press_ctrl;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic exp_p;
  logic exp_h;
  logic exp_d;

  pb_press_ctrl_if bus ();

  pb_press_ctrl #(
    .DEB_CYCLES (4),
    .HOLD_CYCLES(16),
    .CNT_W      (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pb_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n  = 1'b0;
    bus.PB = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.pressed !== 1'b0) begin bad++; $display("FAIL reset_pressed got=%b want=0", bus.pressed); end
    total++; if (bus.held !== 1'b0) begin bad++; $display("FAIL reset_held got=%b want=0", bus.held); end
    total++; if (bus.down !== 1'b0) begin bad++; $display("FAIL reset_down got=%b want=0", bus.down); end
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      total++; if ({bus.pressed, bus.held, bus.down} !== 3'b000) begin bad++; $display("FAIL reset_idle k=%0d got=%b want=000", k, {bus.pressed, bus.held, bus.down}); end
    end
  endtask

  task automatic test_clean_press();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); bus.PB = (k < 10) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      exp_p = (k == 6); exp_h = 1'b0; exp_d = (k >= 6 && k < 16);
      total++; if (bus.pressed !== exp_p) begin bad++; $display("FAIL clean_pressed k=%0d got=%b want=%b", k, bus.pressed, exp_p); end
      total++; if (bus.held !== exp_h) begin bad++; $display("FAIL clean_held k=%0d got=%b want=%b", k, bus.held, exp_h); end
      total++; if (bus.down !== exp_d) begin bad++; $display("FAIL clean_down k=%0d got=%b want=%b", k, bus.down, exp_d); end
    end
  endtask

  // PB low for n_low samples; 3 and 4 must be rejected, 5 accepted.
  task automatic test_glitch(input int n_low);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); bus.PB = (k < n_low) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      exp_p = (n_low >= 5) && (k == 6);
      exp_d = (n_low >= 5) && (k >= 6) && (k < n_low + 6);
      total++; if (bus.pressed !== exp_p) begin bad++; $display("FAIL glitch%0d_pressed k=%0d got=%b want=%b", n_low, k, bus.pressed, exp_p); end
      total++; if (bus.held !== 1'b0) begin bad++; $display("FAIL glitch%0d_held k=%0d got=%b want=0", n_low, k, bus.held); end
      total++; if (bus.down !== exp_d) begin bad++; $display("FAIL glitch%0d_down k=%0d got=%b want=%b", n_low, k, bus.down, exp_d); end
    end
  endtask

  task automatic test_long_hold();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); bus.PB = (k < 30) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      exp_p = (k == 6); exp_h = (k == 22); exp_d = (k >= 6 && k < 36);
      total++; if (bus.pressed !== exp_p) begin bad++; $display("FAIL long_pressed k=%0d got=%b want=%b", k, bus.pressed, exp_p); end
      total++; if (bus.held !== exp_h) begin bad++; $display("FAIL long_held k=%0d got=%b want=%b", k, bus.held, exp_h); end
      total++; if (bus.down !== exp_d) begin bad++; $display("FAIL long_down k=%0d got=%b want=%b", k, bus.down, exp_d); end
    end
  endtask

  // After DOWN, PB = 1,0,1,0 at edges 10..13, then 1 from edge 14.
  task automatic test_release_bounce();
    logic pb_v;
    for (int k = 0; k < 24; k++) begin
      if (k < 10)       pb_v = 1'b0;
      else if (k >= 14) pb_v = 1'b1;
      else              pb_v = (k % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge clk); bus.PB = pb_v;
      @(posedge clk); #1;
      exp_p = (k == 6); exp_d = (k >= 6 && k < 20);
      total++; if (bus.pressed !== exp_p) begin bad++; $display("FAIL relb_pressed k=%0d got=%b want=%b", k, bus.pressed, exp_p); end
      total++; if (bus.held !== 1'b0) begin bad++; $display("FAIL relb_held k=%0d got=%b want=0", k, bus.held); end
      total++; if (bus.down !== exp_d) begin bad++; $display("FAIL relb_down k=%0d got=%b want=%b", k, bus.down, exp_d); end
    end
  endtask

  // PB high at edges 19,20 so the FSM sees the release while hold cnt is 14.
  // REL_DEB after 21,22; back in DOWN after 23 (cnt 14), 24 -> 15, held at 25.
  task automatic test_bounce_at_hold();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); bus.PB = ((k == 19) || (k == 20) || (k >= 40)) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      exp_p = (k == 6); exp_h = (k == 25); exp_d = (k >= 6 && k < 46);
      total++; if (bus.pressed !== exp_p) begin bad++; $display("FAIL bhold_pressed k=%0d got=%b want=%b", k, bus.pressed, exp_p); end
      total++; if (bus.held !== exp_h) begin bad++; $display("FAIL bhold_held k=%0d got=%b want=%b", k, bus.held, exp_h); end
      total++; if (bus.down !== exp_d) begin bad++; $display("FAIL bhold_down k=%0d got=%b want=%b", k, bus.down, exp_d); end
    end
  endtask

  // Release reaches the FSM on the same edge (22) as the hold terminal count.
  task automatic test_simultaneous();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); bus.PB = (k < 20) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      exp_p = (k == 6); exp_d = (k >= 6 && k < 26);
      total++; if (bus.pressed !== exp_p) begin bad++; $display("FAIL simul_pressed k=%0d got=%b want=%b", k, bus.pressed, exp_p); end
      total++; if (bus.held !== 1'b0) begin bad++; $display("FAIL simul_held k=%0d got=%b want=0", k, bus.held); end
      total++; if (bus.down !== exp_d) begin bad++; $display("FAIL simul_down k=%0d got=%b want=%b", k, bus.down, exp_d); end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 23; k++) begin
      @(negedge clk); bus.PB = 1'b0;
      @(posedge clk); #1;
      exp_p = (k == 6); exp_h = (k == 22); exp_d = (k >= 6);
      total++; if (bus.pressed !== exp_p) begin bad++; $display("FAIL areset_pre_pressed k=%0d got=%b want=%b", k, bus.pressed, exp_p); end
      total++; if (bus.held !== exp_h) begin bad++; $display("FAIL areset_pre_held k=%0d got=%b want=%b", k, bus.held, exp_h); end
      total++; if (bus.down !== exp_d) begin bad++; $display("FAIL areset_pre_down k=%0d got=%b want=%b", k, bus.down, exp_d); end
    end
    rst_n = 1'b0;
    #1;
    total++; if ({bus.pressed, bus.held, bus.down} !== 3'b000) begin bad++; $display("FAIL areset_immediate got=%b want=000", {bus.pressed, bus.held, bus.down}); end
    repeat (2) @(posedge clk);
    #1;
    total++; if ({bus.pressed, bus.held, bus.down} !== 3'b000) begin bad++; $display("FAIL areset_during got=%b want=000", {bus.pressed, bus.held, bus.down}); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); bus.PB = (k < 10) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      exp_p = (k == 6); exp_d = (k >= 6 && k < 16);
      total++; if (bus.pressed !== exp_p) begin bad++; $display("FAIL areset_post_pressed k=%0d got=%b want=%b", k, bus.pressed, exp_p); end
      total++; if (bus.held !== 1'b0) begin bad++; $display("FAIL areset_post_held k=%0d got=%b want=0", k, bus.held); end
      total++; if (bus.down !== exp_d) begin bad++; $display("FAIL areset_post_down k=%0d got=%b want=%b", k, bus.down, exp_d); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_clean_press();
    test_glitch(3);
    test_glitch(4);
    test_glitch(5);
    test_long_hold();
    test_release_bounce();
    test_bounce_at_hold();
    test_simultaneous();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
